vcve2_vrf_seq: RTL and testbench
================================

VCVE2_VRF_SEQ -- requirements
Module: vcve2_vrf_seq

Interface
REQ-001 Parameter AddrWidth, default 32, SHALL set the memory address width.
REQ-002 Parameter VlenWords, default 4, SHALL set the number of 32-bit words per vector register (legal range 1..16).
REQ-003 Port clk_i, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1 bit, SHALL be the reset: asynchronous and active-high.
REQ-005 Port start_i, input, 1 bit, SHALL request one vector operation.
REQ-006 Port use_rs1_i / use_rs2_i, input, 1 bit each, SHALL select whether vs1 / vs2 is read; both are sampled on the accepted start_i.
REQ-007 Port busy_o / done_o, output, 1 bit each, SHALL give the operation in progress / the one-cycle completion pulse.
REQ-008 Ports agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, agu_incr_o, output, 1 bit each, SHALL be the address-generator controls.
REQ-009 Port agu_addr_i, input, AddrWidth, SHALL be the word address returned by the address generator.
REQ-010 Ports mem_req_o, mem_we_o, output, 1 bit, and mem_addr_o, output, AddrWidth, SHALL be the VRF memory request.
REQ-011 Port mem_wdata_o, output, 32 bits, SHALL be the write data.
REQ-012 Ports mem_gnt_i, mem_rvalid_i, input, 1 bit, and mem_rdata_i, input, 32 bits, SHALL be the memory responses.
REQ-013 Ports alu_op_a_o / alu_op_b_o, output, 32 bits each, and alu_valid_o, output, 1 bit, SHALL be the operands and their one-cycle strobe.
REQ-014 Port alu_result_i, input, 32 bits, SHALL be the combinational ALU result for the presented operands.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RD1, WT1, RD2, WT2, EXEC, WR, DONE.
REQ-016 IDLE: start_i=1 -> LOAD; latch use flags; word counter := 0; start_i outside IDLE is ignored.
REQ-017 LOAD: agu_load_o=1 for exactly one cycle; next state RD1 if use_rs1 else RD2 if use_rs2 else EXEC.
REQ-018 RD1: mem_req_o=1, mem_we_o=0, agu_get_rs1_o=1; on mem_gnt_i -> WT1.
REQ-019 WT1: agu_get_rs1_o=1, mem_req_o=0; on mem_rvalid_i, alu_op_a_o := mem_rdata_i; then -> RD2 if use_rs2 else EXEC.
REQ-020 RD2/WT2 SHALL mirror RD1/WT1 with agu_get_rs2_o and alu_op_b_o; WT2 -> EXEC.
REQ-021 EXEC: alu_valid_o=1 for one cycle; alu_result_i is registered into mem_wdata_o; -> WR.
REQ-022 WR: mem_req_o=1, mem_we_o=1, agu_get_rd_o=1; on mem_gnt_i the word counter increments and the FSM goes -> DONE if the counter was VlenWords-1, else RD1/RD2/EXEC per REQ-017 (no LOAD).
REQ-023 DONE: done_o=1 for one cycle; -> IDLE.
REQ-024 agu_incr_o SHALL equal mem_req_o AND mem_gnt_i; at most one get_* output is high in any cycle.
REQ-025 mem_addr_o SHALL equal agu_addr_i combinationally.
REQ-026 mem_gnt_i in the same cycle as mem_req_o rises SHALL be accepted; mem_req_o and address hold stable until grant.
REQ-027 At most one request SHALL be outstanding; mem_rvalid_i outside WT1/WT2 is ignored; rvalid may arrive one or more cycles after grant.
REQ-028 Unused operand registers SHALL hold their previous value.
REQ-029 busy_o SHALL be 1 in every state except IDLE.
REQ-030 The word counter SHALL be 4 bits; it is compared against VlenWords-1 with no wrap beyond it.

Reset
REQ-031 rst_i=1 SHALL immediately force IDLE, clear the counter, clear alu_op_a_o, alu_op_b_o and mem_wdata_o, and drive every control output to 0, including mid-operation and with a request pending.
REQ-032 After rst_i falls, the block SHALL wait in IDLE for a new start_i; in-flight rvalid/gnt are ignored.

Verification
REQ-033 VlenWords=4, both sources, zero-wait gnt, rvalid one cycle later -> 4x(RD1,WT1,RD2,WT2,EXEC,WR); 12 grants; 12 agu_incr_o pulses; one agu_load_o; done_o one cycle after the 4th write grant.
REQ-034 use_rs1=1, use_rs2=0, rdata 0x0000_0005, ALU=+1 -> each write carries 0x0000_0006; agu_get_rs2_o never asserted.
REQ-035 mem_gnt_i held 0 for 3 cycles in RD2 -> mem_req_o, mem_addr_o stable for 4 cycles; agu_incr_o only in the grant cycle.
REQ-036 VlenWords=1, no sources -> LOAD, EXEC, WR, DONE; exactly one write.
REQ-037 rst_i asserted during WT1 -> all outputs 0 in the same cycle; a late rvalid is ignored; the next start_i runs a full operation normally.
REQ-038 start_i pulsed while busy_o=1 -> no effect on state, counter or latched flags.

Source files
------------

// File: rtl/vcve2_vrf_seq_if.sv
// rtl/vcve2_vrf_seq_if.sv - VRF memory request/response bundle for the vector sequencer
interface vcve2_vrf_seq_if #(
  parameter int AddrWidth = 32
);
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [31:0]          mem_wdata_o;
  logic                 mem_gnt_i;
  logic                 mem_rvalid_i;
  logic [31:0]          mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/vcve2_vrf_seq.sv
// rtl/vcve2_vrf_seq.sv - word-serial vector op sequencer: read vs1/vs2, run ALU, write vd
module vcve2_vrf_seq #(
  parameter int AddrWidth = 32,
  parameter int VlenWords = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 use_rs1_i,
  input  logic                 use_rs2_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 agu_load_o,
  output logic                 agu_get_rs1_o,
  output logic                 agu_get_rs2_o,
  output logic                 agu_get_rd_o,
  output logic                 agu_incr_o,
  input  logic [AddrWidth-1:0] agu_addr_i,
  output logic [31:0]          alu_op_a_o,
  output logic [31:0]          alu_op_b_o,
  output logic                 alu_valid_o,
  input  logic [31:0]          alu_result_i,
  vcve2_vrf_seq_if.master      bus
);

  typedef enum logic [3:0] {
    IDLE, LOAD, RD1, WT1, RD2, WT2, EXEC, WR, DONE
  } state_e;

  localparam logic [3:0] LastWord = 4'(VlenWords - 1);

  state_e     state, nxt, first_src;
  logic [3:0] word_cnt;
  logic       use_rs1, use_rs2;

  assign bus.mem_addr_o = agu_addr_i;
  assign agu_incr_o     = bus.mem_req_o & bus.mem_gnt_i;

  // Entry point of every word, shared by LOAD and the WR loop-back.
  always_comb begin
    first_src = EXEC;
    if (use_rs1)      first_src = RD1;
    else if (use_rs2) first_src = RD2;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start_i) nxt = LOAD;
      LOAD: nxt = first_src;
      RD1:  if (bus.mem_gnt_i) nxt = WT1;
      WT1:  if (bus.mem_rvalid_i) nxt = use_rs2 ? RD2 : EXEC;
      RD2:  if (bus.mem_gnt_i) nxt = WT2;
      WT2:  if (bus.mem_rvalid_i) nxt = EXEC;
      EXEC: nxt = WR;
      WR:   if (bus.mem_gnt_i) nxt = (word_cnt == LastWord) ? DONE : first_src;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they are flops, not gates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      word_cnt        <= 4'd0;
      use_rs1         <= 1'b0;
      use_rs2         <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      agu_load_o      <= 1'b0;
      agu_get_rs1_o   <= 1'b0;
      agu_get_rs2_o   <= 1'b0;
      agu_get_rd_o    <= 1'b0;
      alu_valid_o     <= 1'b0;
      alu_op_a_o      <= 32'd0;
      alu_op_b_o      <= 32'd0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_wdata_o <= 32'd0;
    end else begin
      state         <= nxt;
      busy_o        <= (nxt != IDLE);
      done_o        <= (nxt == DONE);
      agu_load_o    <= (nxt == LOAD);
      agu_get_rs1_o <= (nxt == RD1) || (nxt == WT1);
      agu_get_rs2_o <= (nxt == RD2) || (nxt == WT2);
      agu_get_rd_o  <= (nxt == WR);
      alu_valid_o   <= (nxt == EXEC);
      bus.mem_req_o <= (nxt == RD1) || (nxt == RD2) || (nxt == WR);
      bus.mem_we_o  <= (nxt == WR);
      case (state)
        IDLE: if (start_i) begin
          use_rs1  <= use_rs1_i;
          use_rs2  <= use_rs2_i;
          word_cnt <= 4'd0;
        end
        WT1:  if (bus.mem_rvalid_i) alu_op_a_o <= bus.mem_rdata_i;
        WT2:  if (bus.mem_rvalid_i) alu_op_b_o <= bus.mem_rdata_i;
        EXEC: bus.mem_wdata_o <= alu_result_i;
        WR:   if (bus.mem_gnt_i) word_cnt <= word_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vcve2_vrf_seq.sv
// tb/tb_vcve2_vrf_seq.sv - directed bench for vcve2_vrf_seq with VlenWords 4 and 1
module tb_vcve2_vrf_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // DUT A: VlenWords = 4
  vcve2_vrf_seq_if #(.AddrWidth(32)) ifa ();
  logic        start_a = 1'b0, use1_a = 1'b0, use2_a = 1'b0;
  logic        busy_a, done_a, load_a, rs1_a, rs2_a, rd_a, incr_a, aluv_a;
  logic [31:0] agu_addr_a = 32'd0;
  logic [31:0] op_a_a, op_b_a, alu_res_a;
  logic        alu_mode = 1'b0, rd_fixed = 1'b0, late_rv = 1'b0;
  int          stall_a = 0;

  assign alu_res_a = alu_mode ? (op_a_a + 32'd1) : (op_a_a + op_b_a);

  vcve2_vrf_seq #(.AddrWidth(32), .VlenWords(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .use_rs1_i(use1_a), .use_rs2_i(use2_a),
    .busy_o(busy_a), .done_o(done_a), .agu_load_o(load_a), .agu_get_rs1_o(rs1_a),
    .agu_get_rs2_o(rs2_a), .agu_get_rd_o(rd_a), .agu_incr_o(incr_a), .agu_addr_i(agu_addr_a),
    .alu_op_a_o(op_a_a), .alu_op_b_o(op_b_a), .alu_valid_o(aluv_a), .alu_result_i(alu_res_a),
    .bus(ifa.master)
  );

  // DUT B: VlenWords = 1
  vcve2_vrf_seq_if #(.AddrWidth(32)) ifb ();
  logic        start_b = 1'b0;
  logic        busy_b, done_b, load_b, rs1_b, rs2_b, rd_b, incr_b, aluv_b;
  logic [31:0] op_a_b, op_b_b;
  logic [31:0] agu_addr_b = 32'h40;
  logic [31:0] alu_res_b = 32'h0000_ABCD;

  vcve2_vrf_seq #(.AddrWidth(32), .VlenWords(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .use_rs1_i(1'b0), .use_rs2_i(1'b0),
    .busy_o(busy_b), .done_o(done_b), .agu_load_o(load_b), .agu_get_rs1_o(rs1_b),
    .agu_get_rs2_o(rs2_b), .agu_get_rd_o(rd_b), .agu_incr_o(incr_b), .agu_addr_i(agu_addr_b),
    .alu_op_a_o(op_a_b), .alu_op_b_o(op_b_b), .alu_valid_o(aluv_b), .alu_result_i(alu_res_b),
    .bus(ifb.master)
  );

  // Memory + address-generator responder for A: optional RD2 stall, rvalid one cycle after grant.
  int   a_rd_cnt = 0, a_wait = 0;
  logic a_rd_granted = 1'b0, a_incr_seen = 1'b0;
  initial begin
    ifa.mem_gnt_i = 1'b0; ifa.mem_rvalid_i = 1'b0; ifa.mem_rdata_i = 32'd0;
    ifb.mem_gnt_i = 1'b0; ifb.mem_rvalid_i = 1'b0; ifb.mem_rdata_i = 32'd0;
  end
  always @(negedge clk) begin
    if (rst) begin
      ifa.mem_gnt_i = 1'b0; ifa.mem_rvalid_i = 1'b0;
      a_rd_granted = 1'b0; a_incr_seen = 1'b0; a_wait = 0;
    end else begin
      if (a_incr_seen) agu_addr_a = agu_addr_a + 32'd1;
      if (load_a) agu_addr_a = 32'h100;
      ifa.mem_rvalid_i = a_rd_granted | late_rv;
      ifa.mem_rdata_i  = late_rv ? 32'hDEAD_BEEF : (rd_fixed ? 32'd5 : 32'(a_rd_cnt));
      if (ifa.mem_req_o && rs2_a && a_wait < stall_a) begin
        ifa.mem_gnt_i = 1'b0; a_wait++;
      end else begin
        ifa.mem_gnt_i = ifa.mem_req_o;
        if (ifa.mem_req_o) a_wait = 0;
      end
      a_rd_granted = ifa.mem_req_o && ifa.mem_gnt_i && !ifa.mem_we_o;
      if (a_rd_granted) a_rd_cnt++;
      a_incr_seen = ifa.mem_req_o && ifa.mem_gnt_i;
    end
  end

  always @(negedge clk) begin
    ifb.mem_gnt_i    = rst ? 1'b0 : ifb.mem_req_o;
    ifb.mem_rvalid_i = 1'b0;
  end

  // Event counters (monotonic; tests use differences)
  int cyc = 0, grants_a = 0, incrs_a = 0, loads_a = 0, rs2cyc_a = 0, done_tot_a = 0;
  int done_cyc_a = 0, wgrant_cyc_a = 0, wr_tot_a = 0;
  logic [31:0] wr_data_a [64];
  logic [31:0] wr_addr_last_a = 32'd0;
  int grants_b = 0, reads_b = 0, loads_b = 0, aluv_tot_b = 0, done_tot_b = 0, wr_tot_b = 0;
  logic [31:0] wdata_last_b = 32'd0;

  always @(posedge clk) begin
    cyc++;
    if (ifa.mem_req_o && ifa.mem_gnt_i) grants_a++;
    if (incr_a) incrs_a++;
    if (load_a) loads_a++;
    if (rs2_a) rs2cyc_a++;
    if (done_a) begin done_tot_a++; done_cyc_a = cyc; end
    if (ifa.mem_req_o && ifa.mem_we_o && ifa.mem_gnt_i) begin
      wr_data_a[wr_tot_a % 64] = ifa.mem_wdata_o;
      wr_addr_last_a = ifa.mem_addr_o;
      wr_tot_a++;
      wgrant_cyc_a = cyc;
    end
    if (ifb.mem_req_o && ifb.mem_gnt_i) grants_b++;
    if (rs1_b || rs2_b) reads_b++;
    if (load_b) loads_b++;
    if (aluv_b) aluv_tot_b++;
    if (done_b) done_tot_b++;
    if (ifb.mem_req_o && ifb.mem_we_o && ifb.mem_gnt_i) begin
      wr_tot_b++; wdata_last_b = ifb.mem_wdata_o;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input logic u1, input logic u2);
    use1_a = u1; use2_a = u2; start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int prev);
    for (int i = 0; i < 400 && done_tot_a == prev; i++) tick();
    chk("done_a_timeout", 32'(done_tot_a != prev), 32'd1);
    tick(); tick();
  endtask

  int s_g, s_i, s_l, s_w, s_d, s_r;
  logic [31:0] saved_addr;
  logic found;

  initial begin
    repeat (3) tick();
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_ctrl", {22'd0, done_a, load_a, rs1_a, rs2_a, rd_a, incr_a, aluv_a,
                       ifa.mem_req_o, ifa.mem_we_o, busy_b}, 32'd0);
    chk("reset_ops", op_a_a | op_b_a | ifa.mem_wdata_o, 32'd0);
    rst = 1'b0;
    tick();

    // Both sources, zero-wait grants
    s_g = grants_a; s_i = incrs_a; s_l = loads_a; s_w = wr_tot_a; s_d = done_tot_a;
    run_a(1'b1, 1'b1);
    wait_done_a(s_d);
    chk("t1_grants", 32'(grants_a - s_g), 32'd12);
    chk("t1_incr", 32'(incrs_a - s_i), 32'd12);
    chk("t1_load", 32'(loads_a - s_l), 32'd1);
    chk("t1_writes", 32'(wr_tot_a - s_w), 32'd4);
    chk("t1_wd0", wr_data_a[s_w], 32'd3);
    chk("t1_wd1", wr_data_a[s_w+1], 32'd7);
    chk("t1_wd2", wr_data_a[s_w+2], 32'd11);
    chk("t1_wd3", wr_data_a[s_w+3], 32'd15);
    chk("t1_wr_addr", wr_addr_last_a, 32'h10B);
    chk("t1_done_lat", 32'(done_cyc_a - wgrant_cyc_a), 32'd1);
    chk("t1_done_cnt", 32'(done_tot_a - s_d), 32'd1);
    chk("t1_idle", 32'(busy_a), 32'd0);

    // rs1 only, ALU = +1, rdata 5
    alu_mode = 1'b1; rd_fixed = 1'b1;
    s_w = wr_tot_a; s_d = done_tot_a; s_r = rs2cyc_a;
    run_a(1'b1, 1'b0);
    wait_done_a(s_d);
    chk("t2_writes", 32'(wr_tot_a - s_w), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_wdata", wr_data_a[s_w+i], 32'd6);
    chk("t2_no_rs2", 32'(rs2cyc_a - s_r), 32'd0);

    // RD2 grant withheld for 3 cycles
    alu_mode = 1'b0; rd_fixed = 1'b0; stall_a = 3;
    s_g = grants_a; s_w = wr_tot_a; s_d = done_tot_a;
    run_a(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (ifa.mem_req_o && rs2_a) found = 1'b1;
      else tick();
    end
    chk("t3_rd2_seen", 32'(found), 32'd1);
    saved_addr = ifa.mem_addr_o;
    for (int j = 0; j < 4; j++) begin
      chk("t3_req_hold", 32'(ifa.mem_req_o), 32'd1);
      chk("t3_addr_hold", ifa.mem_addr_o, saved_addr);
      chk("t3_incr", 32'(incr_a), (j == 3) ? 32'd1 : 32'd0);
      tick();
    end
    stall_a = 0;
    wait_done_a(s_d);
    chk("t3_grants", 32'(grants_a - s_g), 32'd12);
    chk("t3_writes", 32'(wr_tot_a - s_w), 32'd4);

    // Reset during WT1, late rvalid, then a clean run
    run_a(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (rs1_a && !ifa.mem_req_o) found = 1'b1;
      else tick();
    end
    chk("t4_wt1_seen", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("t4_rst_ctrl", {22'd0, busy_a, done_a, load_a, rs1_a, rs2_a, rd_a, incr_a, aluv_a,
                        ifa.mem_req_o, ifa.mem_we_o}, 32'd0);
    chk("t4_rst_ops", op_a_a | op_b_a | ifa.mem_wdata_o, 32'd0);
    tick(); tick();
    rst = 1'b0;
    late_rv = 1'b1;
    tick();
    late_rv = 1'b0;
    tick();
    chk("t4_late_rv_op", op_a_a, 32'd0);
    chk("t4_late_rv_idle", {31'd0, busy_a}, 32'd0);
    s_g = grants_a; s_w = wr_tot_a; s_d = done_tot_a;
    run_a(1'b1, 1'b1);
    wait_done_a(s_d);
    chk("t4_grants", 32'(grants_a - s_g), 32'd12);
    chk("t4_writes", 32'(wr_tot_a - s_w), 32'd4);

    // start while busy must not relaunch or change flags
    s_g = grants_a; s_l = loads_a; s_w = wr_tot_a; s_d = done_tot_a; s_r = rs2cyc_a;
    run_a(1'b1, 1'b0);
    tick(); tick();
    chk("t5_busy", 32'(busy_a), 32'd1);
    use1_a = 1'b0; use2_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(s_d);
    chk("t5_loads", 32'(loads_a - s_l), 32'd1);
    chk("t5_no_rs2", 32'(rs2cyc_a - s_r), 32'd0);
    chk("t5_grants", 32'(grants_a - s_g), 32'd8);
    chk("t5_writes", 32'(wr_tot_a - s_w), 32'd4);
    chk("t5_done", 32'(done_tot_a - s_d), 32'd1);

    // VlenWords = 1, no sources
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 50 && done_tot_b == 0; i++) tick();
    tick();
    chk("t6_done", 32'(done_tot_b), 32'd1);
    chk("t6_loads", 32'(loads_b), 32'd1);
    chk("t6_reads", 32'(reads_b), 32'd0);
    chk("t6_aluv", 32'(aluv_tot_b), 32'd1);
    chk("t6_writes", 32'(wr_tot_b), 32'd1);
    chk("t6_grants", 32'(grants_b), 32'd1);
    chk("t6_wdata", wdata_last_b, 32'h0000_ABCD);
    chk("t6_idle", 32'(busy_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
